vga_sync_gen: RTL
=================

Name: vga_sync_gen

Overview:
- Generates VGA 640x480@60 raster timing from the 100 MHz system clock.
- Outputs: pixel-rate clock enable, hsync/vsync, display-active flag, current pixel coordinates, and line/frame start strobes.
- Sits directly upstream of the pixel-address and colour logic, and supplies the pixel-rate enable and coordinates that logic consumes.

Parameters:
- CLK_DIV, 4, system clocks per pixel (100 MHz -> 25 MHz); must be >= 1
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch, in pixels
- H_SYNC, 96, hsync width, in pixels
- H_BP, 48, horizontal back porch, in pixels
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch, in lines
- V_SYNC, 2, vsync width, in lines
- V_BP, 33, vertical back porch, in lines

Ports:
- clock  in  1  system clock; all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- run  in  1  when low: divider, counters and all outputs freeze
- pix_en  out  1  one-clock pulse per pixel period
- hsync  out  1  horizontal sync, active-low
- vsync  out  1  vertical sync, active-low
- active  out  1  high while (x,y) is inside the visible area
- x  out  $clog2(H_TOTAL)  current horizontal count, 0..H_TOTAL-1
- y  out  $clog2(V_TOTAL)  current vertical count, 0..V_TOTAL-1
- line_start  out  1  one-clock pulse when x becomes 0
- frame_start  out  1  one-clock pulse when (x,y) becomes (0,0)

Behaviour:
- Derived constants:
  - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800)
  - V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525)
- Clock and reset: one clock, `clock`. Reset `reset_n` is asynchronous, active-low. Every output is a flop.
- Reset values:
  - divider = 0, x = H_TOTAL-1, y = V_TOTAL-1
  - pix_en = 0, line_start = 0, frame_start = 0, active = 0
  - hsync = 1, vsync = 1
  - The first tick after reset therefore lands on (0,0) and raises frame_start.
- Divider:
  - Counts 0..CLK_DIV-1 while run=1.
  - pix_en is high for exactly the clock during which the divider equals CLK_DIV-1; the divider wraps to 0 on that edge.
  - CLK_DIV=1: pix_en is held high continuously while run=1.
- Counter advance (on the edge ending a pix_en cycle):
  - x <= (x==H_TOTAL-1) ? 0 : x+1
  - On x wrap: y <= (y==V_TOTAL-1) ? 0 : y+1; otherwise y holds.
- Decode:
  - hsync, vsync, active, line_start and frame_start are computed from the next (x,y) values and registered on the same edge.
  - Result: they are always consistent with the x/y outputs, with zero extra latency.
- Decode rules:
  - hsync low iff H_ACTIVE+H_FP <= x < H_ACTIVE+H_FP+H_SYNC (656..751)
  - vsync low iff V_ACTIVE+V_FP <= y < V_ACTIVE+V_FP+V_SYNC (490..491)
  - active iff x < H_ACTIVE and y < V_ACTIVE
- Strobes:
  - line_start is high for the single clock coincident with pix_en when x==0; frame_start likewise when x==0 and y==0.
  - Both are low on all other clocks, including the remaining CLK_DIV-1 clocks of that pixel.
- run=0:
  - Divider, x, y, hsync, vsync and active hold.
  - pix_en, line_start and frame_start forced low.
  - On return to run=1, counting resumes from the held divider value; no pixel is skipped or repeated.
- Reset mid-frame: all state returns to reset values immediately (asynchronous). The frame restarts at the first tick after release.
- Arithmetic: x/y are unsigned; comparisons are at full width. No overflow beyond H_TOTAL-1 / V_TOTAL-1 is reachable.

Optional Feature:
- Macro: VGA_SYNC_POS_EN
- Defined: hsync and vsync are active-high; reset value is 0.
- Undefined: active-low as above; reset value is 1.
- Counter, timing and strobe behaviour are identical in both cases.

Decomposition:
- Package vga_pkg holds:
  - localparams for the default 640x480 timing
  - derived H_TOTAL/V_TOTAL
  - a typedef struct vga_timing_t bundling the eight timing fields
  - typedefs hcount_t / vcount_t sized by $clog2 of the totals
- One sub-module, clk_en_div: a parameterised CLK_DIV counter with run input and reset_n, emitting pix_en.
- Counters and decode stay in vga_sync_gen.

Test Plan:
- Release reset with run=1:
  - first pix_en on clock 4
  - on that edge x=0, y=0, frame_start=1, line_start=1, active=1
  - frame_start low on the next clock
- Run one line (3200 clocks):
  - hsync goes low at x=656 and returns high at x=752
  - active drops at x=640
  - line_start pulses once at each x wrap
- Run a full frame (1,680,000 clocks):
  - vsync low only for y=490..491
  - y wraps 524->0 with frame_start exactly once
  - 480 lines show active high
- Drop run for 10 clocks at x=100:
  - x, y and syncs hold
  - no pix_en pulses
  - after resume, the next x is 101 and pixel spacing stays 4 clocks
- Assert reset_n at x=400, y=200 asynchronously between edges:
  - outputs go to x=799, y=524, active=0, syncs inactive without waiting for an edge
- Build with VGA_SYNC_POS_EN and repeat the line test:
  - hsync high for x=656..751
  - reset value 0

Source files
------------

// File: rtl/vga_pkg.sv
// vga_pkg: default 640x480@60 timing, derived totals and shared types
// for the VGA raster sync generator.
package vga_pkg;

    localparam int H_ACTIVE_D = 640;
    localparam int H_FP_D     = 16;
    localparam int H_SYNC_D   = 96;
    localparam int H_BP_D     = 48;
    localparam int V_ACTIVE_D = 480;
    localparam int V_FP_D     = 10;
    localparam int V_SYNC_D   = 2;
    localparam int V_BP_D     = 33;

    localparam int H_TOTAL_D = H_ACTIVE_D + H_FP_D + H_SYNC_D + H_BP_D;
    localparam int V_TOTAL_D = V_ACTIVE_D + V_FP_D + V_SYNC_D + V_BP_D;

    typedef struct packed {
        logic [15:0] h_active;
        logic [15:0] h_fp;
        logic [15:0] h_sync;
        logic [15:0] h_bp;
        logic [15:0] v_active;
        logic [15:0] v_fp;
        logic [15:0] v_sync;
        logic [15:0] v_bp;
    } vga_timing_t;

    typedef logic [$clog2(H_TOTAL_D)-1:0] hcount_t;
    typedef logic [$clog2(V_TOTAL_D)-1:0] vcount_t;

endpackage

// File: rtl/vga_sync_gen_clk_en_div.sv
// clk_en_div: divides the system clock into a one-clock pixel enable.
// tick is the combinational "pix_en goes high on this edge" signal.
module clk_en_div #(
    parameter int CLK_DIV = 4
) (
    input  logic clock,
    input  logic reset_n,
    input  logic run,
    output logic tick,
    output logic pix_en
);

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] LAST = DW'(CLK_DIV - 1);

    logic [DW-1:0] r_div;
    logic [DW-1:0] w_div_nxt;

    always_comb begin
        w_div_nxt = (r_div == LAST) ? '0 : r_div + 1'b1;
        tick      = run && (w_div_nxt == LAST);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_div  <= '0;
            pix_en <= 1'b0;
        end else begin
            if (run) r_div <= w_div_nxt;
            pix_en <= tick;
        end
    end

endmodule

// File: rtl/vga_sync_gen.sv
// vga_sync_gen: 640x480@60 raster timing with registered sync/strobes.
// Define VGA_SYNC_POS_EN for active-high hsync/vsync.
module vga_sync_gen
    import vga_pkg::*;
#(
    parameter int CLK_DIV  = 4,
    parameter int H_ACTIVE = H_ACTIVE_D,
    parameter int H_FP     = H_FP_D,
    parameter int H_SYNC   = H_SYNC_D,
    parameter int H_BP     = H_BP_D,
    parameter int V_ACTIVE = V_ACTIVE_D,
    parameter int V_FP     = V_FP_D,
    parameter int V_SYNC   = V_SYNC_D,
    parameter int V_BP     = V_BP_D
) (
    input  logic clock,
    input  logic reset_n,
    input  logic run,
    output logic pix_en,
    output logic hsync,
    output logic vsync,
    output logic active,
    output logic [$clog2(H_ACTIVE+H_FP+H_SYNC+H_BP)-1:0] x,
    output logic [$clog2(V_ACTIVE+V_FP+V_SYNC+V_BP)-1:0] y,
    output logic line_start,
    output logic frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int XW = $clog2(H_TOTAL);
    localparam int YW = $clog2(V_TOTAL);

    localparam vga_timing_t T = '{
        h_active: 16'(H_ACTIVE), h_fp: 16'(H_FP),
        h_sync:   16'(H_SYNC),   h_bp: 16'(H_BP),
        v_active: 16'(V_ACTIVE), v_fp: 16'(V_FP),
        v_sync:   16'(V_SYNC),   v_bp: 16'(V_BP)
    };

    localparam logic [XW-1:0] X_LAST = XW'(H_TOTAL - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(V_TOTAL - 1);
    localparam logic [XW-1:0] X_ACT  = XW'(T.h_active);
    localparam logic [YW-1:0] Y_ACT  = YW'(T.v_active);
    localparam logic [XW-1:0] HS_BEG = XW'(T.h_active + T.h_fp);
    localparam logic [XW-1:0] HS_END = XW'(T.h_active + T.h_fp + T.h_sync);
    localparam logic [YW-1:0] VS_BEG = YW'(T.v_active + T.v_fp);
    localparam logic [YW-1:0] VS_END = YW'(T.v_active + T.v_fp + T.v_sync);

`ifdef VGA_SYNC_POS_EN
    localparam logic SYNC_ON = 1'b1;
`else
    localparam logic SYNC_ON = 1'b0;
`endif

    logic          w_tick;
    logic [XW-1:0] w_x_nxt;
    logic [YW-1:0] w_y_nxt;
    logic          w_hs_on;
    logic          w_vs_on;

    clk_en_div #(
        .CLK_DIV(CLK_DIV)
    ) u_div (
        .clock  (clock),
        .reset_n(reset_n),
        .run    (run),
        .tick   (w_tick),
        .pix_en (pix_en)
    );

    // Decode the next position so flags line up with x/y on the same edge.
    always_comb begin
        w_x_nxt = (x == X_LAST) ? '0 : x + 1'b1;
        w_y_nxt = y;
        if (x == X_LAST) w_y_nxt = (y == Y_LAST) ? '0 : y + 1'b1;
        w_hs_on = (w_x_nxt >= HS_BEG) && (w_x_nxt < HS_END);
        w_vs_on = (w_y_nxt >= VS_BEG) && (w_y_nxt < VS_END);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            x           <= X_LAST;
            y           <= Y_LAST;
            hsync       <= ~SYNC_ON;
            vsync       <= ~SYNC_ON;
            active      <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            if (w_tick) begin
                x           <= w_x_nxt;
                y           <= w_y_nxt;
                hsync       <= w_hs_on ? SYNC_ON : ~SYNC_ON;
                vsync       <= w_vs_on ? SYNC_ON : ~SYNC_ON;
                active      <= (w_x_nxt < X_ACT) && (w_y_nxt < Y_ACT);
                line_start  <= (w_x_nxt == '0);
                frame_start <= (w_x_nxt == '0) && (w_y_nxt == '0);
            end
        end
    end

endmodule
